mem_lane_ctrl: RTL and testbench

MEM_LANE_CTRL -- requirements
Module: mem_lane_ctrl

---
 rtl/mem_lane_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_lane_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lane_ctrl.sv
// mem_lane_ctrl: Wishbone-style slave that maps one 64 KiB window onto four
// byte-wide memory lanes. Each request is decoded in IDLE, held for
// WAIT_STATES+1 ACCESS cycles, and then finished with a one-cycle ack (or a
// one-cycle err for an address outside the window or an empty byte select).
// Every output comes straight from a flop.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wb_cyc_i/wb_stb_i   bus cycle / strobe; a request is cyc & stb
//   wb_we_i             1 = write, 0 = read
//   wb_adr_i[31:0]      byte address: [31:16] window, [15:2] word index
//   wb_sel_i[3:0]       byte enables, bit n selects lane n
//   wb_dat_i[31:0]      write data
//   wb_dat_o[31:0]      read data, valid while wb_ack_o is high
//   wb_ack_o, wb_err_o  one-cycle normal / error termination
//   mem_adr[13:0]       word address shared by all lanes
//   mem_en[3:0]         per-lane enable
//   mem_we[3:0]         per-lane write enable (always within mem_en)
//   mem_dat_o[31:0]     lane write data, byte n to lane n
//   mem_dat_i[31:0]     lane read data, byte n from lane n
module mem_lane_ctrl #(
  parameter logic [15:0] BASE_ADR    = 16'h0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [13:0] mem_adr,
  output logic [3:0]  mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_dat_o,
  input  logic [31:0] mem_dat_i
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ADR_W   = 14;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANES   = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2,
    ERR    = 2'd3
  } state_e;

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [LANES-1:0]    sel_q,     sel_d;
  logic                wr_q,      wr_d;
  logic [ADR_W-1:0]    adr_q,     adr_d;
  logic [DATA_W-1:0]   wdat_q,    wdat_d;
  logic [DATA_W-1:0]   rdat_q,    rdat_d;
  logic [LANES-1:0]    en_q,      en_d;
  logic [LANES-1:0]    we_q,      we_d;
  logic                ack_q,     ack_d;
  logic                err_q,     err_d;

  logic                req;
  logic                bad_req;
  logic                last_access;
  logic                commit_next;
  logic [DATA_W-1:0]   lane_mask;
  logic                unused_adr_bits;

  // Byte offset within a word has no meaning for a word-wide lane array.
  assign unused_adr_bits = ^wb_adr_i[1:0];

  assign req         = wb_cyc_i & wb_stb_i;
  assign bad_req     = (wb_adr_i[31:16] != BASE_ADR) || (wb_sel_i == 4'b0000);
  assign last_access = (cnt_q == LAST_CNT);
  // The write strobe is registered, so it is raised on the edge that enters
  // the final ACCESS cycle.
  assign commit_next = ((cnt_q + CNT_W'(1)) == LAST_CNT);

  // Expand the latched byte selects into a bit mask so unselected lanes read 0.
  always_comb begin
    lane_mask = '0;
    for (int n = 0; n < LANES; n++) begin
      lane_mask[8*n +: 8] = {8{sel_q[n]}};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    en_d    = '0;
    we_d    = '0;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          sel_d  = wb_sel_i;
          wr_d   = wb_we_i;
          adr_d  = wb_adr_i[15:2];
          wdat_d = wb_dat_i;
          cnt_d  = '0;
          if (bad_req) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            en_d    = wb_sel_i;
            // With no wait states the first ACCESS cycle is also the commit cycle.
            we_d    = (wb_we_i && (LAST_CNT == '0)) ? wb_sel_i : '0;
          end
        end
      end

      ACCESS: begin
        if (!wb_cyc_i) begin
          // Master withdrew the cycle: drop the lanes, no termination.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last_access) begin
          state_d = ACK;
          ack_d   = 1'b1;
          cnt_d   = '0;
          if (!wr_q) begin
            rdat_d = mem_dat_i & lane_mask;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          en_d  = sel_q;
          we_d  = (wr_q && commit_next) ? sel_q : '0;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      ERR: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      en_q    <= '0;
      we_q    <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      en_q    <= en_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign wb_dat_o  = rdat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign mem_adr   = adr_q;
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_dat_o = wdat_q;

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// tb_mem_lane_ctrl: directed bench for mem_lane_ctrl. Instance 0 has no wait
// states, instance 1 has three. Each instance has its own four-lane byte
// memory; disabled lanes return a junk byte so leakage into read data shows up.
module tb_mem_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [31:0] adr  [2];
  logic [3:0]  sel  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        ack  [2];
  logic        err  [2];
  logic [13:0] madr [2];
  logic [3:0]  men  [2];
  logic [3:0]  mwe  [2];
  logic [31:0] mdo  [2];
  logic [31:0] mdi  [2];

  logic [7:0]  mem [2][4][64];
  int          commits [2] = '{0, 0};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_lane_ctrl #(.BASE_ADR(16'h0000), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_adr_i(adr[0]),
    .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
    .wb_ack_o(ack[0]), .wb_err_o(err[0]),
    .mem_adr(madr[0]), .mem_en(men[0]), .mem_we(mwe[0]),
    .mem_dat_o(mdo[0]), .mem_dat_i(mdi[0])
  );

  mem_lane_ctrl #(.BASE_ADR(16'h0000), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_adr_i(adr[1]),
    .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
    .wb_ack_o(ack[1]), .wb_err_o(err[1]),
    .mem_adr(madr[1]), .mem_en(men[1]), .mem_we(mwe[1]),
    .mem_dat_o(mdo[1]), .mem_dat_i(mdi[1])
  );

  // Lane memories: asynchronous read, write on the clock edge under mem_we.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    for (genvar n = 0; n < 4; n++) begin : g_lane
      assign mdi[g][8*n +: 8] = men[g][n] ? mem[g][n][madr[g][5:0]] : 8'h5A;
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (mwe[g] != 4'b0000) begin
        commits[g] <= commits[g] + 1;
        for (int n = 0; n < 4; n++) begin
          if (mwe[g][n]) mem[g][n][madr[g][5:0]] <= mdo[g][8*n +: 8];
        end
      end
    end
  end

  // Cycle-by-cycle invariants: exclusive terminations, write lanes within enables.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 2; g++) begin
        n_checks++;
        assert ((ack[g] & err[g]) === 1'b0) else begin
          n_errors++;
          $error("FAIL ack_err_excl[%0d]: observed ack=%b err=%b required not both", g, ack[g], err[g]);
        end
        n_checks++;
        assert ((mwe[g] & ~men[g]) === 4'b0000) else begin
          n_errors++;
          $error("FAIL we_subset_en[%0d]: observed we=%b en=%b required we within en", g, mwe[g], men[g]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transaction on instance g, bounded to 20 cycles. Reports latency
  // (cycles from driving the request to the termination being visible), the
  // termination, read data, lanes enabled, write-strobe cycles and the word
  // address during the write strobe, and whether a termination lingered.
  task automatic txn(input int g, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] d,
                     output int lat, output logic got_ack, output logic got_err,
                     output logic [31:0] rd, output logic [3:0] en_or,
                     output int we_cyc, output logic [13:0] we_adr,
                     output logic linger);
    cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = w; adr[g] = a; sel[g] = s; wdat[g] = d;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = '0; en_or = '0;
    we_cyc = 0; we_adr = '0;
    while (!got_ack && !got_err && lat < 20) begin
      tick();
      lat++;
      en_or = en_or | men[g];
      if (mwe[g] != 4'b0000) begin
        we_cyc++;
        we_adr = madr[g];
      end
      got_ack = ack[g];
      got_err = err[g];
      rd      = rdat[g];
    end
    cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
    tick();
    linger = ack[g] | err[g];
  endtask

  int          lat, we_cyc, c_before, acc_cnt;
  logic        got_ack, got_err, linger;
  logic [31:0] rd;
  logic [3:0]  en_or;
  logic [13:0] we_adr;
  logic [5:0]  ack_pat;

  initial begin
    for (int g = 0; g < 2; g++) begin
      cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
      adr[g] = '0; sel[g] = '0; wdat[g] = '0;
    end

    // Reset state.
    tick(); tick();
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_ack%0d", g),  32'(ack[g]),  32'h0);
      check($sformatf("rst_err%0d", g),  32'(err[g]),  32'h0);
      check($sformatf("rst_dat%0d", g),  rdat[g],      32'h0);
      check($sformatf("rst_en%0d", g),   32'(men[g]),  32'h0);
      check($sformatf("rst_we%0d", g),   32'(mwe[g]),  32'h0);
      check($sformatf("rst_madr%0d", g), 32'(madr[g]), 32'h0);
      check($sformatf("rst_mdo%0d", g),  mdo[g],       32'h0);
    end

    // Full-word write at 0x10: one strobe cycle at word 4, ack two cycles later.
    c_before = commits[0];
    txn(0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("wr_lat",     32'(lat),      32'd2);
    check("wr_ack",     32'(got_ack),  32'h1);
    check("wr_en",      32'(en_or),    32'hF);
    check("wr_we_cyc",  32'(we_cyc),   32'd1);
    check("wr_we_adr",  32'(we_adr),   32'h004);
    check("wr_commits", 32'(commits[0] - c_before), 32'd1);
    check("wr_linger",  32'(linger),   32'h0);

    txn(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("rd_full_dat", rd,          32'hDEADBEEF);
    check("rd_full_lat", 32'(lat),    32'd2);
    check("rd_full_we",  32'(we_cyc), 32'd0);

    // Single-lane read: only lane 2 enabled, other bytes zero.
    txn(0, 1'b0, 32'h0000_0010, 4'b0100, 32'h0, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("rd_lane2_dat", rd,          32'h00AD0000);
    check("rd_lane2_en",  32'(en_or),  32'h4);
    check("rd_lane2_ack", 32'(got_ack), 32'h1);

    // Partial write on lanes 0 and 1 merges into the stored word.
    txn(0, 1'b1, 32'h0000_0010, 4'b0011, 32'h11223344, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    txn(0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("rd_merge_dat", rd, 32'hDEAD3344);

    // Preload words 0 and 1 for the error and back-to-back cases.
    txn(0, 1'b1, 32'h0000_0000, 4'hF, 32'hA0A1A2A3, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    txn(0, 1'b1, 32'h0000_0004, 4'hF, 32'hB0B1B2B3, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);

    // Outside the window: err one cycle after the request, lanes untouched.
    c_before = commits[0];
    txn(0, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFFFFFF, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("err_adr_lat",    32'(lat),     32'd1);
    check("err_adr_err",    32'(got_err), 32'h1);
    check("err_adr_ack",    32'(got_ack), 32'h0);
    check("err_adr_en",     32'(en_or),   32'h0);
    check("err_adr_linger", 32'(linger),  32'h0);
    check("err_adr_commit", 32'(commits[0] - c_before), 32'd0);

    // Empty byte select is an error too.
    txn(0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("err_sel_err", 32'(got_err), 32'h1);
    check("err_sel_en",  32'(en_or),   32'h0);

    // Back-to-back reads of words 0 and 1 with cyc/stb held throughout.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0000_0000; sel[0] = 4'hF;
    ack_pat = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ack_pat[i] = ack[0];
      if (ack[0] && adr[0] == 32'h0000_0000) begin
        check("b2b_dat0", rdat[0], 32'hA0A1A2A3);
        adr[0] = 32'h0000_0004;
      end else if (ack[0]) begin
        check("b2b_dat1", rdat[0], 32'hB0B1B2B3);
        cyc[0] = 1'b0; stb[0] = 1'b0;
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    check("b2b_ack_pattern", 32'(ack_pat), 32'h12);

    // Three wait states: write word 8, ack after five cycles, one strobe cycle.
    c_before = commits[1];
    txn(1, 1'b1, 32'h0000_0020, 4'hF, 32'hCAFEF00D, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("ws3_wr_lat",    32'(lat),    32'd5);
    check("ws3_wr_we_cyc", 32'(we_cyc), 32'd1);
    check("ws3_wr_commit", 32'(commits[1] - c_before), 32'd1);

    // Abort: cyc dropped during the second ACCESS cycle of a write.
    c_before = commits[1];
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h0000_0020;
    sel[1] = 4'hF; wdat[1] = 32'h12345678;
    tick();
    check("abort_en_first", 32'(men[1]), 32'hF);
    tick();
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack[1] || mwe[1] != 4'b0000 || men[1] != 4'b0000) acc_cnt++;
    end
    check("abort_activity", 32'(acc_cnt), 32'd0);
    check("abort_commit",   32'(commits[1] - c_before), 32'd0);
    txn(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("abort_after_dat", rd,       32'hCAFEF00D);
    check("abort_after_lat", 32'(lat), 32'd5);

    // stb withdrawn while cyc stays high does not abort.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h0000_0020; sel[1] = 4'b1000;
    tick();
    stb[1] = 1'b0;
    lat = 1;
    while (!ack[1] && lat < 20) begin
      tick();
      lat++;
    end
    check("stb_drop_lat", 32'(lat), 32'd5);
    check("stb_drop_dat", rdat[1],  32'hCA000000);
    cyc[1] = 1'b0;
    tick();

    // Reset in the middle of a write's ACCESS phase.
    c_before = commits[1];
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h0000_0020;
    sel[1] = 4'hF; wdat[1] = 32'h0BADBEEF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_ack",  32'(ack[1]),  32'h0);
    check("rstmid_err",  32'(err[1]),  32'h0);
    check("rstmid_dat",  rdat[1],      32'h0);
    check("rstmid_en",   32'(men[1]),  32'h0);
    check("rstmid_we",   32'(mwe[1]),  32'h0);
    check("rstmid_madr", 32'(madr[1]), 32'h0);
    check("rstmid_mdo",  mdo[1],       32'h0);
    rst = 1'b0;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    tick();
    check("rstmid_commit", 32'(commits[1] - c_before), 32'd0);
    txn(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, lat, got_ack, got_err, rd, en_or, we_cyc, we_adr, linger);
    check("rstmid_mem", rd, 32'hCAFEF00D);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
